t07_simon_sequence_player: RTL and testbench

Drives the Simon module's colour display. It sits directly downstream of `t07_simon_press_detector` and consumes its `simon_state_out`. In display states it flashes the stored colour sequence for the current stage, repeating after a gap. On any direction press it echoes the pressed colour so the player sees their input.

---
 rtl/t07_pkg.sv | 65 ++++++
 rtl/t07_phase_timer.sv | 24 ++
 rtl/t07_simon_sequence_player.sv | 137 +++++++++++++
 tb/tb_t07_simon_sequence_player.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/t07_pkg.sv
// Shared definitions for the t07 puzzle modules: game modes, module select,
// button codes, Simon detector states and colours.
package t07_pkg;

  // Game mode
  localparam logic [1:0] MODE_MENU = 2'd0;
  localparam logic [1:0] MODE_PLAY = 2'd1;
  localparam logic [1:0] MODE_LOST = 2'd2;
  localparam logic [1:0] MODE_WON  = 2'd3;

  // Module select
  localparam logic [2:0] SEL_MOD   = 3'd0;
  localparam logic [2:0] SEL_MAZE  = 3'd1;
  localparam logic [2:0] SEL_WIRE  = 3'd2;
  localparam logic [2:0] SEL_MEM   = 3'd3;
  localparam logic [2:0] SEL_SIMON = 3'd4;

  // One-hot button codes
  localparam logic [5:0] BTN_SELECT = 6'b000001;
  localparam logic [5:0] BTN_UP     = 6'b000010;
  localparam logic [5:0] BTN_RIGHT  = 6'b000100;
  localparam logic [5:0] BTN_DOWN   = 6'b001000;
  localparam logic [5:0] BTN_LEFT   = 6'b010000;
  localparam logic [5:0] BTN_BACK   = 6'b100000;

  // Simon detector states: even = display, odd = input
  typedef enum logic [3:0] {
    SS_D1 = 4'd0, SS_I1 = 4'd1,
    SS_D2 = 4'd2, SS_I2 = 4'd3,
    SS_D3 = 4'd4, SS_I3 = 4'd5,
    SS_D4 = 4'd6, SS_I4 = 4'd7,
    SS_D5 = 4'd8, SS_I5 = 4'd9
  } simon_state_t;

  typedef enum logic [1:0] {
    COL_BLUE   = 2'd0,
    COL_YELLOW = 2'd1,
    COL_GREEN  = 2'd2,
    COL_RED    = 2'd3
  } colour_t;

  // Sequence player FSM states
  typedef enum logic [2:0] {
    PS_IDLE, PS_GAP, PS_ON, PS_OFF, PS_ECHO
  } player_state_t;

  // True for a single direction button
  function automatic logic is_direction(input logic [5:0] btn);
    case (btn)
      BTN_UP, BTN_RIGHT, BTN_DOWN, BTN_LEFT: is_direction = 1'b1;
      default:                               is_direction = 1'b0;
    endcase
  endfunction

  // Colour echoed for a direction button
  function automatic logic [1:0] direction_colour(input logic [5:0] btn);
    case (btn)
      BTN_RIGHT: direction_colour = 2'd1;
      BTN_DOWN:  direction_colour = 2'd2;
      BTN_LEFT:  direction_colour = 2'd3;
      default:   direction_colour = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/t07_phase_timer.sv
// Phase counter: counts from 0 each cycle, flags done at the loaded limit,
// synchronous clear restarts the count.
module t07_phase_timer #(
  parameter int unsigned CNT_W = 24
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             clr,
  input  logic [CNT_W-1:0] limit,
  output logic             done
);

  logic [CNT_W-1:0] cnt;

  // Free-running phase count, cleared on every phase change
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)    cnt <= '0;
    else if (clr) cnt <= '0;
    else          cnt <= cnt + CNT_W'(1);
  end

  assign done = (cnt == limit);

endmodule

// File: rtl/t07_simon_sequence_player.sv
// Simon colour display: plays back the stored sequence in display states and
// echoes direction presses.
module t07_simon_sequence_player
  import t07_pkg::*;
#(
  parameter int unsigned FLASH_ON   = 6_000_000,
  parameter int unsigned FLASH_OFF  = 3_000_000,
  parameter int unsigned REPEAT_GAP = 12_000_000,
  parameter int unsigned CNT_W      = 24
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic [2:0] playing_state_in,
  input  logic       simon_cleared,
  input  logic [3:0] simon_state_in,
  input  logic [9:0] simon_sequence_bus,
  input  logic       strobe,
  input  logic [5:0] button,
  output logic       led_on,
  output logic [1:0] led_color,
  output logic       playing
);

  localparam logic [CNT_W-1:0] ON_LIM  = CNT_W'(FLASH_ON - 1);
  localparam logic [CNT_W-1:0] OFF_LIM = CNT_W'(FLASH_OFF - 1);
  localparam logic [CNT_W-1:0] GAP_LIM = CNT_W'(REPEAT_GAP - 1);

  player_state_t    state;
  logic [2:0]       idx;
  logic [1:0]       echo_col;
  logic [3:0]       prev_state;

  logic             active;
  logic             press;
  logic [1:0]       press_col;
  logic             restart;
  logic [2:0]       last;
  logic [CNT_W-1:0] limit;
  logic             clr;
  logic             done;

  // Control decode: activity, press, restart, phase length and timer clear
  always_comb begin
    active    = (playing_state_in == SEL_SIMON) && !simon_cleared;
    press     = strobe && is_direction(button);
    press_col = direction_colour(button);
    restart   = (state != PS_IDLE) && (simon_state_in != prev_state) &&
                !simon_state_in[0];
    last      = (simon_state_in[3:1] > 3'd4) ? 3'd4 : simon_state_in[3:1];
    case (state)
      PS_GAP:  limit = GAP_LIM;
      PS_OFF:  limit = OFF_LIM;
      default: limit = ON_LIM;
    endcase
    // Every state change coincides with one of these, so the timer restarts at 0
    clr = !active || restart || press || done || (state == PS_IDLE);
  end

  t07_phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk   (clk),
    .nrst  (nrst),
    .clr   (clr),
    .limit (limit),
    .done  (done)
  );

  // Playback / echo state machine
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state      <= PS_IDLE;
      idx        <= '0;
      echo_col   <= '0;
      prev_state <= '0;
    end else begin
      prev_state <= simon_state_in;
      if (!active) begin
        state <= PS_IDLE;
        idx   <= '0;
      end else if (restart) begin
        state <= PS_GAP;
        idx   <= '0;
      end else if (press) begin
        state    <= PS_ECHO;
        echo_col <= press_col;
      end else begin
        case (state)
          PS_IDLE: if (!simon_state_in[0]) begin
            state <= PS_GAP;
            idx   <= '0;
          end
          PS_GAP: if (done) state <= PS_ON;
          PS_ON:  if (done) state <= PS_OFF;
          PS_OFF: if (done) begin
            if (idx == last) begin
              state <= PS_GAP;
              idx   <= '0;
            end else begin
              state <= PS_ON;
              idx   <= idx + 3'd1;
            end
          end
          PS_ECHO: if (done) begin
            if (!simon_state_in[0]) begin
              state <= PS_GAP;
              idx   <= '0;
            end else begin
              state <= PS_IDLE;
            end
          end
          default: state <= PS_IDLE;
        endcase
      end
    end
  end

  // Moore output decode; sequence colour taken live from the bus
  always_comb begin
    led_on    = 1'b0;
    led_color = 2'd0;
    playing   = (state == PS_GAP) || (state == PS_ON) || (state == PS_OFF);
    if (state == PS_ON) begin
      led_on = 1'b1;
      case (idx)
        3'd0:    led_color = simon_sequence_bus[1:0];
        3'd1:    led_color = simon_sequence_bus[3:2];
        3'd2:    led_color = simon_sequence_bus[5:4];
        3'd3:    led_color = simon_sequence_bus[7:6];
        3'd4:    led_color = simon_sequence_bus[9:8];
        default: led_color = 2'd0;
      endcase
    end else if (state == PS_ECHO) begin
      led_on    = 1'b1;
      led_color = echo_col;
    end
  end

endmodule

// File: tb/tb_t07_simon_sequence_player.sv
// Directed bench for the Simon sequence player with short phase lengths.
module tb_t07_simon_sequence_player;

  logic       clk;
  logic       nrst;
  logic [2:0] playing_state_in;
  logic       simon_cleared;
  logic [3:0] simon_state_in;
  logic [9:0] simon_sequence_bus;
  logic       strobe;
  logic [5:0] button;
  logic       led_on;
  logic [1:0] led_color;
  logic       playing;

  int checks = 0;
  int errors = 0;

  t07_simon_sequence_player #(
    .FLASH_ON   (4),
    .FLASH_OFF  (2),
    .REPEAT_GAP (3),
    .CNT_W      (24)
  ) dut (
    .clk                (clk),
    .nrst               (nrst),
    .playing_state_in   (playing_state_in),
    .simon_cleared      (simon_cleared),
    .simon_state_in     (simon_state_in),
    .simon_sequence_bus (simon_sequence_bus),
    .strobe             (strobe),
    .button             (button),
    .led_on             (led_on),
    .led_color          (led_color),
    .playing            (playing)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic on, input logic [1:0] col,
                       input logic play);
    logic [3:0] obs;
    logic [3:0] exp;
    obs = {led_on, led_color, playing};
    exp = {on, col, play};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed{on,col,play}=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Advance n cycles, checking the same output triple after each edge
  task automatic expect_n(input string tag, input int n, input logic on,
                          input logic [1:0] col, input logic play);
    for (int i = 0; i < n; i++) begin
      tick();
      check(tag, on, col, play);
    end
  endtask

  initial begin
    nrst               = 1'b0;
    playing_state_in   = 3'd0;
    simon_cleared      = 1'b0;
    simon_state_in     = 4'd0;
    simon_sequence_bus = 10'b01_10_00_11_10;  // c0=2 c1=3 c2=0 c3=2 c4=1
    strobe             = 1'b0;
    button             = 6'd0;

    repeat (2) @(posedge clk);
    #1;
    check("in_reset", 1'b0, 2'd0, 1'b0);
    nrst = 1'b1;
    expect_n("menu_idle", 1, 1'b0, 2'd0, 1'b0);

    // Stage 1 playback
    playing_state_in = 3'd4;
    simon_state_in   = 4'd0;
    check("idle_cycle", 1'b0, 2'd0, 1'b0);
    expect_n("s1_gap",   3, 1'b0, 2'd0, 1'b1);
    expect_n("s1_on",    4, 1'b1, 2'd2, 1'b1);
    expect_n("s1_off",   2, 1'b0, 2'd0, 1'b1);
    expect_n("s1_gap2",  3, 1'b0, 2'd0, 1'b1);
    expect_n("s1_on2",   4, 1'b1, 2'd2, 1'b1);

    // Stage 3 playback, restarted by the state change
    simon_state_in = 4'd4;
    expect_n("s3_gap",   3, 1'b0, 2'd0, 1'b1);
    expect_n("s3_on0",   4, 1'b1, 2'd2, 1'b1);
    expect_n("s3_off0",  2, 1'b0, 2'd0, 1'b1);
    expect_n("s3_on1",   4, 1'b1, 2'd3, 1'b1);
    expect_n("s3_off1",  2, 1'b0, 2'd0, 1'b1);
    expect_n("s3_on2",   4, 1'b1, 2'd0, 1'b1);
    expect_n("s3_off2",  2, 1'b0, 2'd0, 1'b1);
    expect_n("s3_gap2",  3, 1'b0, 2'd0, 1'b1);
    expect_n("s3_rep0",  4, 1'b1, 2'd2, 1'b1);

    // Stage 2, then 2->4 during OFF restarts from idx 0
    simon_state_in = 4'd2;
    expect_n("s2_gap",   3, 1'b0, 2'd0, 1'b1);
    expect_n("s2_on0",   4, 1'b1, 2'd2, 1'b1);
    expect_n("s2_off0",  1, 1'b0, 2'd0, 1'b1);
    simon_state_in = 4'd4;
    expect_n("rst_gap",  3, 1'b0, 2'd0, 1'b1);
    expect_n("rst_on0",  4, 1'b1, 2'd2, 1'b1);
    expect_n("rst_off0", 2, 1'b0, 2'd0, 1'b1);
    expect_n("rst_on1",  4, 1'b1, 2'd3, 1'b1);
    expect_n("rst_off1", 2, 1'b0, 2'd0, 1'b1);
    expect_n("rst_on2",  2, 1'b1, 2'd0, 1'b1);

    // Leave the module during ON
    playing_state_in = 3'd0;
    expect_n("menu_idle2", 3, 1'b0, 2'd0, 1'b0);
    playing_state_in = 3'd4;
    expect_n("back_gap", 3, 1'b0, 2'd0, 1'b1);
    expect_n("back_on0", 2, 1'b1, 2'd2, 1'b1);
    simon_cleared = 1'b1;
    expect_n("cleared_idle", 2, 1'b0, 2'd0, 1'b0);

    // Echo mid-playback, state then moves to an input state
    simon_cleared  = 1'b0;
    simon_state_in = 4'd0;
    expect_n("e_gap",    3, 1'b0, 2'd0, 1'b1);
    expect_n("e_on0",    2, 1'b1, 2'd2, 1'b1);
    strobe = 1'b1;
    button = 6'b010000;
    expect_n("echo_left", 1, 1'b1, 2'd3, 1'b0);
    strobe = 1'b0;
    button = 6'd0;
    simon_state_in = 4'd1;
    expect_n("echo_left_hold", 3, 1'b1, 2'd3, 1'b0);
    expect_n("echo_to_idle",   2, 1'b0, 2'd0, 1'b0);

    // Echo from IDLE in an input state
    strobe = 1'b1;
    button = 6'b001000;
    expect_n("echo_down", 1, 1'b1, 2'd2, 1'b0);
    strobe = 1'b0;
    button = 6'd0;
    expect_n("echo_down_hold", 3, 1'b1, 2'd2, 1'b0);
    expect_n("echo_down_idle", 2, 1'b0, 2'd0, 1'b0);

    // Ignored button codes
    strobe = 1'b1;
    button = 6'b000001;
    expect_n("ign_select", 1, 1'b0, 2'd0, 1'b0);
    button = 6'b100000;
    expect_n("ign_back",   1, 1'b0, 2'd0, 1'b0);
    button = 6'b000110;
    expect_n("ign_multi",  1, 1'b0, 2'd0, 1'b0);
    button = 6'd0;
    expect_n("ign_zero",   1, 1'b0, 2'd0, 1'b0);
    strobe = 1'b0;
    button = 6'b001000;
    expect_n("ign_nostrobe", 1, 1'b0, 2'd0, 1'b0);
    button = 6'd0;

    // A press during ECHO restarts the full window
    strobe = 1'b1;
    button = 6'b000010;
    expect_n("echo_up", 1, 1'b1, 2'd0, 1'b0);
    strobe = 1'b0;
    button = 6'd0;
    expect_n("echo_up_hold", 1, 1'b1, 2'd0, 1'b0);
    strobe = 1'b1;
    button = 6'b000100;
    expect_n("echo_right", 1, 1'b1, 2'd1, 1'b0);
    strobe = 1'b0;
    button = 6'd0;
    expect_n("echo_right_hold", 3, 1'b1, 2'd1, 1'b0);
    expect_n("echo_right_idle", 1, 1'b0, 2'd0, 1'b0);

    // Echo with display state held returns to GAP
    simon_state_in = 4'd0;
    expect_n("d_gap", 1, 1'b0, 2'd0, 1'b1);
    strobe = 1'b1;
    button = 6'b010000;
    expect_n("d_echo", 1, 1'b1, 2'd3, 1'b0);
    strobe = 1'b0;
    button = 6'd0;
    expect_n("d_echo_hold", 3, 1'b1, 2'd3, 1'b0);
    expect_n("d_echo_gap",  3, 1'b0, 2'd0, 1'b1);
    expect_n("d_echo_on",   1, 1'b1, 2'd2, 1'b1);

    // Restart beats a same-cycle press
    simon_state_in = 4'd2;
    strobe = 1'b1;
    button = 6'b000010;
    expect_n("restart_wins", 1, 1'b0, 2'd0, 1'b1);
    strobe = 1'b0;
    button = 6'd0;
    expect_n("restart_gap", 2, 1'b0, 2'd0, 1'b1);
    expect_n("restart_on",  2, 1'b1, 2'd2, 1'b1);

    // Asynchronous reset mid-ON
    #2;
    nrst = 1'b0;
    #1;
    check("async_reset", 1'b0, 2'd0, 1'b0);
    tick();
    nrst = 1'b1;
    check("post_reset_idle", 1'b0, 2'd0, 1'b0);
    expect_n("post_reset_gap", 3, 1'b0, 2'd0, 1'b1);
    expect_n("post_reset_on",  1, 1'b1, 2'd2, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
